// File: rtl/conv_acc_pkg.sv
// Shared constants and FSM state type for the convolution accelerator's
// post-processing blocks.
package conv_acc_pkg;

  localparam int unsigned NUM_CLASS = 10;
  localparam int unsigned RES_W     = 32;
  localparam int unsigned CLS_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/res_argmax.sv
// Serial argmax over a captured vector of signed class scores: one compare
// per cycle, lowest index wins on ties, result held until taken downstream.
module res_argmax #(
  parameter int unsigned NUM_CLASS = conv_acc_pkg::NUM_CLASS,
  parameter int unsigned RES_W     = conv_acc_pkg::RES_W,
  parameter int unsigned CLS_W     = conv_acc_pkg::CLS_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pre_valid,
  output logic                       o_pre_ready,
  input  logic [NUM_CLASS*RES_W-1:0] i_res,
  output logic                       o_post_valid,
  input  logic                       i_post_ready,
  output logic [CLS_W-1:0]           o_class,
  output logic [RES_W-1:0]           o_max
);

  import conv_acc_pkg::*;

  localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [RES_W-1:0] res_buf [NUM_CLASS];
  logic signed [RES_W-1:0] best;
  logic signed [RES_W-1:0] best_nxt;
  logic [CLS_W-1:0]        idx;
  logic [CLS_W-1:0]        idx_nxt;
  logic [CLS_W-1:0]        cnt;
  logic                    accept;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshakes and the running compare
  always_comb begin
    state_nxt   = state;
    o_pre_ready = 1'b0;
    accept      = 1'b0;
    best_nxt    = best;
    idx_nxt     = idx;
    case (state)
      IDLE: begin
        o_pre_ready = 1'b1;
        if (i_pre_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // strict greater-than keeps the earlier index on ties
        if (res_buf[cnt] > best) begin
          best_nxt = res_buf[cnt];
          idx_nxt  = cnt;
        end
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_post_ready) begin
          o_pre_ready = 1'b1;
          if (i_pre_valid) begin
            accept    = 1'b1;
            state_nxt = SCAN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture buffer, scan registers and held result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      best         <= '0;
      idx          <= '0;
      cnt          <= '0;
      o_post_valid <= 1'b0;
      o_class      <= '0;
      o_max        <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NUM_CLASS; k++) begin
          res_buf[k] <= i_res[k*RES_W +: RES_W];
        end
        best <= i_res[RES_W-1:0];
        idx  <= '0;
        cnt  <= CLS_W'(1);
      end else if (state == SCAN) begin
        best <= best_nxt;
        idx  <= idx_nxt;
        // cnt parks on the last index instead of wrapping
        if (cnt != LAST) begin
          cnt <= cnt + 1'b1;
        end
      end

      if (state == SCAN && cnt == LAST) begin
        o_post_valid <= 1'b1;
        o_class      <= idx_nxt;
        o_max        <= best_nxt;
      end else if (state == DONE && i_post_ready) begin
        o_post_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_res_argmax.sv
// Bench for res_argmax: reference argmax plus handshake/latency model,
// checked every cycle, with directed and randomized stimulus.
module tb_res_argmax;

  localparam int NC = 10;
  localparam int RW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pre_valid;
  logic            pre_ready;
  logic [NC*RW-1:0] res;
  logic            post_valid;
  logic            post_ready;
  logic [CW-1:0]   cls;
  logic [RW-1:0]   mx;

  res_argmax #(.NUM_CLASS(NC), .RES_W(RW), .CLS_W(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pre_valid (pre_valid),
    .o_pre_ready (pre_ready),
    .i_res       (res),
    .o_post_valid(post_valid),
    .i_post_ready(post_ready),
    .o_class     (cls),
    .o_max       (mx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state
  bit            pend    = 1'b0;
  int            t_ready = 0;
  int            acc_cnt = 0;
  int            acc_hs  = 0;
  int            p_cls   = 0;
  int            out_cls = 0;
  logic [RW-1:0] p_max   = '0;
  logic [RW-1:0] out_max = '0;
  bit            mv, mr, ev, er;
  bit            chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // argmax by definition: first occurrence of the largest signed word
  function automatic void ref_argmax(input logic [NC*RW-1:0] v, output int c, output logic [RW-1:0] m);
    logic signed [RW-1:0] w;
    logic signed [RW-1:0] top;
    top = $signed(v[RW-1:0]);
    c   = 0;
    for (int k = 1; k < NC; k++) begin
      w = $signed(v[k*RW +: RW]);
      if (w > top) begin
        top = w;
        c   = k;
      end
    end
    m = top;
  endfunction

  // Transaction-level model: a result is pending from accept until taken,
  // and becomes visible NC cycles after the handshake cycle.
  always @(posedge clk) begin
    mv = pend && (cyc >= t_ready);
    mr = !pend || (mv && post_ready);
    if (rst) begin
      pend    = 1'b0;
      out_cls = 0;
      out_max = '0;
    end else begin
      if (mv && post_ready) pend = 1'b0;
      if (pre_valid && mr) begin
        ref_argmax(res, p_cls, p_max);
        pend    = 1'b1;
        acc_hs  = cyc;
        t_ready = cyc + NC;
        acc_cnt++;
      end
    end
    cyc++;
    if (pend && cyc == t_ready) begin
      out_cls = p_cls;
      out_max = p_max;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      ev = pend && (cyc >= t_ready);
      er = !pend || (ev && post_ready);
      chk("post_valid", post_valid, ev);
      chk("pre_ready", pre_ready, er);
      chk("class", cls, out_cls);
      chk("max", mx, out_max);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [NC*RW-1:0] vec, input int exp_c, input logic [RW-1:0] exp_m,
                         input int hold);
    int            c;
    logic [RW-1:0] m;
    int            start;
    int            n;
    ref_argmax(vec, c, m);
    chk("model_cls", c, exp_c);
    chk("model_max", m, exp_m);
    res        = vec;
    pre_valid  = 1'b1;
    post_ready = (hold == 0);
    start      = acc_cnt;
    n          = 0;
    while (acc_cnt == start && n < 50) begin
      step();
      n++;
    end
    pre_valid = 1'b0;
    chk("accepted", acc_cnt - start, 1);
    n = 0;
    while (!post_valid && n < 30) begin
      step();
      n++;
    end
    chk("latency", cyc - acc_hs, NC);
    chk("result_cls", cls, exp_c);
    chk("result_max", mx, exp_m);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_valid", post_valid, 1);
      chk("bp_pre_ready", pre_ready, 0);
      chk("bp_cls", cls, exp_c);
      chk("bp_max", mx, exp_m);
    end
    post_ready = 1'b1;
    step();
    chk("valid_drop", post_valid, 0);
  endtask

  function automatic logic [RW-1:0] rand_word();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return RW'(int'($urandom_range(0, 6)) - 3);
    if (sel == 1) return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return RW'($urandom);
  endfunction

  logic [NC*RW-1:0] v;
  logic [NC*RW-1:0] vb;
  int               vc [2];
  int               nv;
  int               start;
  int               n;

  initial begin
    rst        = 1'b1;
    pre_valid  = 1'b0;
    post_ready = 1'b0;
    res        = '0;
    step();
    chk_en = 1'b1;
    // reset holds off a handshake even with valid asserted
    pre_valid = 1'b1;
    step();
    chk("rst_post_valid", post_valid, 0);
    chk("rst_class", cls, 0);
    chk("rst_max", mx, 0);
    chk("rst_pre_ready", pre_ready, 1);
    rst       = 1'b0;
    pre_valid = 1'b0;
    step();
    chk("idle_pre_ready", pre_ready, 1);

    // ascending scores
    for (int k = 0; k < NC; k++) v[k*RW +: RW] = RW'(k);
    run_vec(v, 9, 32'd9, 0);

    // negative scores, signed compare
    for (int k = 0; k < NC; k++) v[k*RW +: RW] = RW'(-100 + k);
    v[3*RW +: RW] = 32'hFFFF_FFFF;
    run_vec(v, 3, 32'hFFFF_FFFF, 0);

    // ties, lowest index wins
    v = '0;
    v[2*RW +: RW] = 32'd50;
    v[7*RW +: RW] = 32'd50;
    run_vec(v, 2, 32'd50, 0);

    // backpressure for 20 cycles
    for (int k = 0; k < NC; k++) v[k*RW +: RW] = RW'(k * 7 % 5);
    v[6*RW +: RW] = 32'd123;
    run_vec(v, 6, 32'd123, 20);

    // back-to-back
    for (int k = 0; k < NC; k++) begin
      v[k*RW +: RW]  = rand_word();
      vb[k*RW +: RW] = rand_word();
    end
    vb[0 +: RW] = v[0 +: RW] + 32'd1;
    res        = v;
    pre_valid  = 1'b1;
    post_ready = 1'b1;
    start      = acc_cnt;
    nv         = 0;
    n          = 0;
    while (nv < 2 && n < 60) begin
      step();
      n++;
      if (acc_cnt == start + 1) res = vb;
      if (acc_cnt >= start + 2) pre_valid = 1'b0;
      if (post_valid) begin
        vc[nv] = cyc;
        nv++;
      end
    end
    pre_valid = 1'b0;
    chk("b2b_count", nv, 2);
    chk("b2b_period", vc[1] - vc[0], NC);
    chk("b2b_same_edge", acc_hs, vc[0]);
    chk("b2b_accepts", acc_cnt - start, 2);

    // reset in the middle of a scan
    for (int k = 0; k < NC; k++) v[k*RW +: RW] = RW'(NC - k);
    res       = v;
    pre_valid = 1'b1;
    start     = acc_cnt;
    n         = 0;
    while (acc_cnt == start && n < 50) begin
      step();
      n++;
    end
    pre_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("abort_valid", post_valid, 0);
    chk("abort_class", cls, 0);
    chk("abort_max", mx, 0);
    chk("abort_pre_ready", pre_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("abort_no_result", post_valid, 0);
    end

    // randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      pre_valid  = ($urandom_range(0, 3) != 0);
      post_ready = ($urandom_range(0, 9) < 7);
      rst        = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NC; k++) res[k*RW +: RW] = rand_word();
      step();
    end
    rst       = 1'b0;
    pre_valid = 1'b0;
    post_ready = 1'b1;
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
